// File: rtl/sad_min_tracker_pkg.sv
// Shared motion-estimation constants and FSM state encoding for the SAD
// minimum tracker.
package sad_min_tracker_pkg;
  localparam int PE_COUNT  = 16;
  localparam int ROW_COUNT = 16;
  localparam int SAD_WIDTH = 16;
  localparam int MV_WIDTH  = 5;
  localparam int MV_OFFSET = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;
endpackage

// File: rtl/sad_min_tracker_if.sv
// Result handshake between the tracker (master) and the MV consumer (slave).
interface sad_min_tracker_if
  import sad_min_tracker_pkg::*;
#(
  parameter int SAD_WIDTH = sad_min_tracker_pkg::SAD_WIDTH,
  parameter int MV_WIDTH  = sad_min_tracker_pkg::MV_WIDTH
);
  logic                        out_mv_valid;
  logic                        in_mv_ready;
  logic signed [MV_WIDTH-1:0]  out_mv_x;
  logic signed [MV_WIDTH-1:0]  out_mv_y;
  logic        [SAD_WIDTH-1:0] out_min_sad;

  modport master (output out_mv_valid, out_mv_x, out_mv_y, out_min_sad, input in_mv_ready);
  modport slave  (input out_mv_valid, out_mv_x, out_mv_y, out_min_sad, output in_mv_ready);
endinterface

// File: rtl/sad_min_tracker_pe_sad_select.sv
// Lowest-index priority encoder over the PE done strobes plus the matching
// SAD mux; also flags when more than one PE reports in the same cycle.
module pe_sad_select
  import sad_min_tracker_pkg::*;
#(
  parameter int PE_COUNT  = sad_min_tracker_pkg::PE_COUNT,
  parameter int SAD_WIDTH = sad_min_tracker_pkg::SAD_WIDTH,
  parameter int IDX_W     = $clog2(PE_COUNT)
) (
  input  logic [PE_COUNT*SAD_WIDTH-1:0] i_pe_sad,
  input  logic [PE_COUNT-1:0]           i_pe_done,
  output logic                          o_any_done,
  output logic                          o_multi_hot,
  output logic [IDX_W-1:0]              o_index,
  output logic [SAD_WIDTH-1:0]          o_sad
);
  always_comb begin
    o_index = '0;
    // Scan downwards so the lowest set bit is the last one written.
    for (int i = PE_COUNT - 1; i >= 0; i--) begin
      if (i_pe_done[i]) o_index = IDX_W'(i);
    end
  end

  assign o_any_done  = |i_pe_done;
  assign o_multi_hot = |(i_pe_done & (i_pe_done - PE_COUNT'(1)));
  assign o_sad       = i_pe_sad[o_index*SAD_WIDTH +: SAD_WIDTH];
endmodule

// File: rtl/sad_min_tracker.sv
// Tracks the minimum SAD over a full 16x16 candidate search and presents the
// winning motion vector on a valid/ready handshake.
module sad_min_tracker
  import sad_min_tracker_pkg::*;
#(
  parameter int PE_COUNT  = sad_min_tracker_pkg::PE_COUNT,
  parameter int ROW_COUNT = sad_min_tracker_pkg::ROW_COUNT,
  parameter int SAD_WIDTH = sad_min_tracker_pkg::SAD_WIDTH,
  parameter int MV_WIDTH  = sad_min_tracker_pkg::MV_WIDTH
) (
  input  logic                          in_clk,
  input  logic                          in_rst,
  input  logic                          in_start,
  input  logic [PE_COUNT*SAD_WIDTH-1:0] in_pe_sad,
  input  logic [PE_COUNT-1:0]           in_pe_done,
  sad_min_tracker_if.master             mv_if,
  output logic                          out_busy,
  output logic                          out_err
);
  localparam int COL_W = $clog2(PE_COUNT);
  localparam int ROW_W = $clog2(ROW_COUNT);
  localparam int TOTAL = PE_COUNT * ROW_COUNT;
  localparam int CNT_W = $clog2(TOTAL) + 1;

  function automatic logic signed [MV_WIDTH-1:0] to_mv(input logic [MV_WIDTH-1:0] idx);
    return $signed(idx - MV_WIDTH'(MV_OFFSET));
  endfunction

  state_t                 r_state, w_state_nxt;
  logic                   w_init, w_accept;
  logic                   w_any_done, w_multi_hot;
  logic [COL_W-1:0]       w_sel_idx;
  logic [SAD_WIDTH-1:0]   w_sel_sad;
  logic                   w_cand_ok, w_enter_done;

  logic [ROW_W-1:0]       r_row;
  logic                   r_vld_p1;
  logic [SAD_WIDTH-1:0]   r_sad_p1;
  logic [COL_W-1:0]       r_col_p1;
  logic [ROW_W-1:0]       r_row_p1;

  logic [SAD_WIDTH-1:0]   r_min_sad_p2;
  logic [COL_W-1:0]       r_best_col_p2;
  logic [ROW_W-1:0]       r_best_row_p2;
  logic [CNT_W-1:0]       r_cand_cnt;
  logic                   r_last_p2;

  logic                       r_mv_valid;
  logic signed [MV_WIDTH-1:0] r_mv_x, r_mv_y;
  logic [SAD_WIDTH-1:0]       r_min_sad_out;
  logic                       r_err;

  pe_sad_select #(
    .PE_COUNT  (PE_COUNT),
    .SAD_WIDTH (SAD_WIDTH),
    .IDX_W     (COL_W)
  ) u_sel (
    .i_pe_sad    (in_pe_sad),
    .i_pe_done   (in_pe_done),
    .o_any_done  (w_any_done),
    .o_multi_hot (w_multi_hot),
    .o_index     (w_sel_idx),
    .o_sad       (w_sel_sad)
  );

  assign w_accept     = r_mv_valid && mv_if.in_mv_ready;
  assign w_cand_ok    = r_vld_p1 && (r_cand_cnt < CNT_W'(TOTAL));
  assign w_enter_done = (r_state == SEARCH) && (w_state_nxt == DONE);

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_init      = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_start) begin
          w_state_nxt = SEARCH;
          w_init      = 1'b1;
        end
      end
      SEARCH: begin
        if (in_start)       w_init      = 1'b1;
        else if (r_last_p2) w_state_nxt = DONE;
      end
      DONE: begin
        if (w_accept) begin
          w_state_nxt = in_start ? SEARCH : IDLE;
          w_init      = in_start;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Stage 1: capture the selected PE result and the row it belongs to.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      r_vld_p1 <= 1'b0;
      r_row    <= '0;
    end else if (w_init) begin
      r_vld_p1 <= 1'b0;
      r_row    <= '0;
    end else if (r_state == SEARCH) begin
      r_vld_p1 <= w_any_done;
      if (w_any_done && (w_sel_idx == COL_W'(PE_COUNT - 1))) r_row <= r_row + 1'b1;
    end else begin
      r_vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge in_clk) begin
    if (w_any_done) begin
      r_sad_p1 <= w_sel_sad;
      r_col_p1 <= w_sel_idx;
      r_row_p1 <= r_row;
    end
  end

  // Stage 2: strict-less-than compare keeps the earliest candidate on ties.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      r_min_sad_p2  <= '1;
      r_best_col_p2 <= '0;
      r_best_row_p2 <= '0;
      r_cand_cnt    <= '0;
      r_last_p2     <= 1'b0;
    end else if (w_init) begin
      r_min_sad_p2  <= '1;
      r_best_col_p2 <= '0;
      r_best_row_p2 <= '0;
      r_cand_cnt    <= '0;
      r_last_p2     <= 1'b0;
    end else begin
      r_last_p2 <= (r_state == SEARCH) && w_cand_ok && (r_cand_cnt == CNT_W'(TOTAL - 1));
      if ((r_state == SEARCH) && w_cand_ok) begin
        r_cand_cnt <= r_cand_cnt + 1'b1;
        if (r_sad_p1 < r_min_sad_p2) begin
          r_min_sad_p2  <= r_sad_p1;
          r_best_col_p2 <= r_col_p1;
          r_best_row_p2 <= r_row_p1;
        end
      end
    end
  end

  // Output stage: result registers load only on entry to DONE.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      r_mv_valid    <= 1'b0;
      r_mv_x        <= '0;
      r_mv_y        <= '0;
      r_min_sad_out <= '0;
    end else if (w_enter_done) begin
      r_mv_valid    <= 1'b1;
      r_mv_x        <= to_mv(MV_WIDTH'(r_best_col_p2));
      r_mv_y        <= to_mv(MV_WIDTH'(r_best_row_p2));
      r_min_sad_out <= r_min_sad_p2;
    end else if (w_accept) begin
      r_mv_valid    <= 1'b0;
    end
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst)                                       r_err <= 1'b0;
    else if (w_init)                                  r_err <= 1'b0;
    else if (w_any_done && (r_state != SEARCH))       r_err <= 1'b1;
    else if (w_any_done && w_multi_hot)               r_err <= 1'b1;
  end

  assign mv_if.out_mv_valid = r_mv_valid;
  assign mv_if.out_mv_x     = r_mv_x;
  assign mv_if.out_mv_y     = r_mv_y;
  assign mv_if.out_min_sad  = r_min_sad_out;
  assign out_busy           = (r_state == SEARCH);
  assign out_err            = r_err;
endmodule

// File: tb/tb_sad_min_tracker.sv
// Randomised bench for sad_min_tracker with a candidate-list reference model.
module tb_sad_min_tracker;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [255:0] pe_sad = '0;
  logic [15:0]  pe_done = '0;
  logic         busy, err;
  int           chk_cnt = 0;
  int           pass_cnt = 0;

  sad_min_tracker_if #(.SAD_WIDTH(16), .MV_WIDTH(5)) mv_if ();

  sad_min_tracker dut (
    .in_clk     (clk),
    .in_rst     (rst),
    .in_start   (start),
    .in_pe_sad  (pe_sad),
    .in_pe_done (pe_done),
    .mv_if      (mv_if),
    .out_busy   (busy),
    .out_err    (err)
  );

  always #5 clk = ~clk;

  // Reference model: list of candidates in the order taken, row advancing
  // whenever the last PE reports.
  typedef struct { int row; int col; int sad; } cand_t;
  cand_t q[$];
  int    m_row;
  int    grid[256];

  function automatic void model_clear();
    q.delete();
    m_row = 0;
  endfunction

  function automatic void model_apply(input logic [15:0] mask, input logic [255:0] vec);
    int idx;
    cand_t c;
    if (mask == 16'h0) return;
    idx = 0;
    while (mask[idx] == 1'b0) idx++;
    c.row = m_row; c.col = idx; c.sad = int'(vec[idx*16 +: 16]);
    q.push_back(c);
    if (idx == 15) m_row = (m_row + 1) % 16;
  endfunction

  function automatic void model_expect(output int ex, output int ey, output int es);
    int br, bc, n;
    es = 65535; br = 0; bc = 0;
    n = (q.size() < 256) ? q.size() : 256;
    for (int k = 0; k < n; k++) begin
      if (q[k].sad < es) begin es = q[k].sad; br = q[k].row; bc = q[k].col; end
    end
    ex = bc - 8; ey = br - 8;
  endfunction

  task automatic drive(input logic [15:0] mask, input logic [255:0] vec);
    @(negedge clk);
    pe_done = mask; pe_sad = vec;
    model_apply(mask, vec);
    @(posedge clk); #1;
    pe_done = '0;
  endtask

  task automatic send_grid(input int lo, input int hi, input int max_gap);
    logic [255:0] vec;
    for (int i = lo; i < hi; i++) begin
      for (int p = 0; p < 16; p++) vec[p*16 +: 16] = 16'($urandom);
      vec[(i%16)*16 +: 16] = 16'(grid[i]);
      drive(16'(1) << (i % 16), vec);
      if (max_gap > 0 && i != hi - 1) repeat ($urandom_range(0, max_gap)) @(posedge clk);
    end
    #0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    model_clear();
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic hard_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; pe_done = '0; mv_if.in_mv_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; pe_done = '0; mv_if.in_mv_ready = 1'b0;
    @(posedge clk); #1;
    chk_cnt++; if (mv_if.out_mv_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", mv_if.out_mv_valid); else pass_cnt++;
    chk_cnt++; if (mv_if.out_mv_x !== 5'd0) $display("FAIL reset_mv_x got %0d want 0", mv_if.out_mv_x); else pass_cnt++;
    chk_cnt++; if (mv_if.out_mv_y !== 5'd0) $display("FAIL reset_mv_y got %0d want 0", mv_if.out_mv_y); else pass_cnt++;
    chk_cnt++; if (mv_if.out_min_sad !== 16'd0) $display("FAIL reset_min_sad got %0d want 0", mv_if.out_min_sad); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy); else pass_cnt++;
    chk_cnt++; if (err !== 1'b0) $display("FAIL reset_err got %0b want 0", err); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_search(input string name, input int mode, input int max_gap);
    int ex, ey, es;
    hard_reset();
    pulse_start();
    chk_cnt++; if (busy !== 1'b1) $display("FAIL %s busy_rise got %0b want 1", name, busy); else pass_cnt++;
    for (int i = 0; i < 256; i++) grid[i] = (mode == 0) ? 1000 : int'($urandom_range(1, 65535));
    if (mode == 0) grid[3*16 + 11] = 200;
    if (mode == 1) begin grid[0] = 0; grid[255] = 0; end
    send_grid(0, 256, max_gap);
    chk_cnt++; if (mv_if.out_mv_valid !== 1'b0) $display("FAIL %s valid_early0 got %0b want 0", name, mv_if.out_mv_valid); else pass_cnt++;
    @(posedge clk); #1;
    chk_cnt++; if (mv_if.out_mv_valid !== 1'b0) $display("FAIL %s valid_early1 got %0b want 0", name, mv_if.out_mv_valid); else pass_cnt++;
    @(posedge clk); #1;
    chk_cnt++; if (mv_if.out_mv_valid !== 1'b1) $display("FAIL %s valid_at2 got %0b want 1", name, mv_if.out_mv_valid); else pass_cnt++;
    model_expect(ex, ey, es);
    chk_cnt++; if (int'(mv_if.out_mv_x) !== ex) $display("FAIL %s mv_x got %0d want %0d", name, mv_if.out_mv_x, ex); else pass_cnt++;
    chk_cnt++; if (int'(mv_if.out_mv_y) !== ey) $display("FAIL %s mv_y got %0d want %0d", name, mv_if.out_mv_y, ey); else pass_cnt++;
    chk_cnt++; if (int'(mv_if.out_min_sad) !== es) $display("FAIL %s min_sad got %0d want %0d", name, mv_if.out_min_sad, es); else pass_cnt++;
    chk_cnt++; if (err !== 1'b0 || busy !== 1'b0) $display("FAIL %s err_busy got %0b%0b want 00", name, err, busy); else pass_cnt++;
    @(negedge clk); mv_if.in_mv_ready = 1'b1;
    @(posedge clk); #1; mv_if.in_mv_ready = 1'b0;
    chk_cnt++; if (mv_if.out_mv_valid !== 1'b0) $display("FAIL %s valid_after_accept got %0b want 0", name, mv_if.out_mv_valid); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int ex, ey, es;
    hard_reset();
    pulse_start();
    for (int i = 0; i < 256; i++) grid[i] = int'($urandom_range(0, 65535));
    send_grid(0, 256, 1);
    repeat (2) @(posedge clk); #1;
    model_expect(ex, ey, es);
    for (int c = 0; c < 20; c++) begin
      chk_cnt++;
      if (mv_if.out_mv_valid !== 1'b1 || int'(mv_if.out_mv_x) !== ex || int'(mv_if.out_mv_y) !== ey || int'(mv_if.out_min_sad) !== es)
        $display("FAIL bp_hold c%0d got v%0b x%0d y%0d s%0d want v1 x%0d y%0d s%0d", c, mv_if.out_mv_valid, mv_if.out_mv_x, mv_if.out_mv_y, mv_if.out_min_sad, ex, ey, es);
      else pass_cnt++;
      @(posedge clk); #1;
    end
    drive(16'h0040, {16{16'd1}});
    chk_cnt++; if (err !== 1'b1) $display("FAIL bp_done_in_done err got %0b want 1", err); else pass_cnt++;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    chk_cnt++; if (mv_if.out_mv_valid !== 1'b1 || busy !== 1'b0 || int'(mv_if.out_min_sad) !== es) $display("FAIL bp_start_ignored got v%0b b%0b s%0d want v1 b0 s%0d", mv_if.out_mv_valid, busy, mv_if.out_min_sad, es); else pass_cnt++;
    @(negedge clk); mv_if.in_mv_ready = 1'b1;
    @(posedge clk); #1; mv_if.in_mv_ready = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk_cnt++; if (mv_if.out_mv_valid !== 1'b0 || busy !== 1'b0) $display("FAIL bp_accept got v%0b b%0b want v0 b0", mv_if.out_mv_valid, busy); else pass_cnt++;
  endtask

  task automatic test_multi_hot();
    int ex, ey, es;
    logic [255:0] vec;
    hard_reset();
    pulse_start();
    for (int i = 0; i < 256; i++) grid[i] = int'($urandom_range(100, 65535));
    send_grid(0, 50, 0);
    for (int p = 0; p < 16; p++) vec[p*16 +: 16] = 16'd9000;
    vec[0 +: 16] = 16'd5; vec[32 +: 16] = 16'd1;
    drive(16'h0005, vec);
    chk_cnt++; if (err !== 1'b1) $display("FAIL mh_err got %0b want 1", err); else pass_cnt++;
    send_grid(51, 256, 0);
    repeat (2) @(posedge clk); #1;
    model_expect(ex, ey, es);
    chk_cnt++; if (mv_if.out_mv_valid !== 1'b1) $display("FAIL mh_valid got %0b want 1", mv_if.out_mv_valid); else pass_cnt++;
    chk_cnt++; if (int'(mv_if.out_min_sad) !== es || int'(mv_if.out_mv_x) !== ex || int'(mv_if.out_mv_y) !== ey)
      $display("FAIL mh_result got x%0d y%0d s%0d want x%0d y%0d s%0d", mv_if.out_mv_x, mv_if.out_mv_y, mv_if.out_min_sad, ex, ey, es); else pass_cnt++;
  endtask

  task automatic test_restart();
    int ex, ey, es;
    hard_reset();
    pulse_start();
    for (int i = 0; i < 256; i++) grid[i] = int'($urandom_range(0, 40));
    grid[5] = 0;
    send_grid(0, 100, 0);
    pulse_start();
    chk_cnt++; if (busy !== 1'b1) $display("FAIL rs_busy got %0b want 1", busy); else pass_cnt++;
    for (int i = 0; i < 256; i++) grid[i] = int'($urandom_range(50, 65535));
    send_grid(0, 255, 1);
    repeat (3) @(posedge clk); #1;
    chk_cnt++; if (mv_if.out_mv_valid !== 1'b0) $display("FAIL rs_valid_early got %0b want 0", mv_if.out_mv_valid); else pass_cnt++;
    send_grid(255, 256, 0);
    repeat (2) @(posedge clk); #1;
    model_expect(ex, ey, es);
    chk_cnt++; if (mv_if.out_mv_valid !== 1'b1 || int'(mv_if.out_min_sad) !== es || int'(mv_if.out_mv_x) !== ex || int'(mv_if.out_mv_y) !== ey)
      $display("FAIL rs_result got v%0b x%0d y%0d s%0d want v1 x%0d y%0d s%0d", mv_if.out_mv_valid, mv_if.out_mv_x, mv_if.out_mv_y, mv_if.out_min_sad, ex, ey, es); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    int ex, ey, es;
    hard_reset();
    pulse_start();
    for (int i = 0; i < 256; i++) grid[i] = 3000;
    grid[10*16 + 12] = 7;
    send_grid(0, 256, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); mv_if.in_mv_ready = 1'b1; start = 1'b1;
    @(posedge clk); #1; mv_if.in_mv_ready = 1'b0; start = 1'b0;
    model_clear();
    send_grid(0, 50, 0);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk_cnt++; if (mv_if.out_mv_valid !== 1'b0 || mv_if.out_mv_x !== 5'd0 || mv_if.out_mv_y !== 5'd0 || mv_if.out_min_sad !== 16'd0 || busy !== 1'b0 || err !== 1'b0)
      $display("FAIL ar_outputs got v%0b x%0d y%0d s%0d b%0b e%0b want all 0", mv_if.out_mv_valid, mv_if.out_mv_x, mv_if.out_mv_y, mv_if.out_min_sad, busy, err); else pass_cnt++;
    @(negedge clk); rst = 1'b0;
    pulse_start();
    for (int i = 0; i < 256; i++) grid[i] = int'($urandom_range(0, 65535));
    send_grid(0, 256, 0);
    repeat (2) @(posedge clk); #1;
    model_expect(ex, ey, es);
    chk_cnt++; if (mv_if.out_mv_valid !== 1'b1 || int'(mv_if.out_min_sad) !== es || int'(mv_if.out_mv_x) !== ex || int'(mv_if.out_mv_y) !== ey)
      $display("FAIL ar_result got v%0b x%0d y%0d s%0d want v1 x%0d y%0d s%0d", mv_if.out_mv_valid, mv_if.out_mv_x, mv_if.out_mv_y, mv_if.out_min_sad, ex, ey, es); else pass_cnt++;
  endtask

  initial begin
    mv_if.in_mv_ready = 1'b0;
    model_clear();
    test_reset();
    test_search("single", 0, 0);
    test_search("tie", 1, 2);
    for (int r = 0; r < 3; r++) test_search("random", 2, 3);
    test_backpressure();
    test_multi_hot();
    test_restart();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
